// File: rtl/floo_pkg.sv
// Shared types and helpers for the AXI performance monitor: default AXI
// request/response structs, window counter sizing and saturating add.
package floo_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [5:0]  atop;
    } axi_aw_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } axi_w_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
    } axi_ar_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } axi_b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi_r_chan_t;

    typedef struct packed {
        axi_aw_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        axi_b_chan_t b;
        logic        b_valid;
        axi_r_chan_t r;
        logic        r_valid;
    } axi_rsp_t;

    function automatic int unsigned win_cnt_width(input int unsigned window_cycles);
        return $clog2(window_cycles);
    endfunction

    // Adds a and b, clamping the result to the all-ones value of a width-bit counter.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned width);
        logic [64:0] sum;
        logic [63:0] max_val;
        max_val = {64{1'b1}} >> (64 - width);
        sum     = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[63:0];
    endfunction

endpackage

// File: rtl/floo_axi_perf_port.sv
// Per-port counters: outstanding reads/writes with high-water marks,
// windowed R/W beat accumulators and a sticky underflow flag.
module floo_axi_perf_port
    import floo_pkg::*;
#(
    parameter int unsigned CntWidth = 32,
    parameter type         req_t    = axi_req_t,
    parameter type         rsp_t    = axi_rsp_t
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                clear_i,
    input  logic                tc_i,
    input  req_t                req_i,
    input  rsp_t                rsp_i,
    output logic [CntWidth-1:0] r_beats_o,
    output logic [CntWidth-1:0] w_beats_o,
    output logic [CntWidth-1:0] ar_in_flight_o,
    output logic [CntWidth-1:0] aw_in_flight_o,
    output logic [CntWidth-1:0] max_ar_in_flight_o,
    output logic [CntWidth-1:0] max_aw_in_flight_o,
    output logic                error_o
);

    localparam logic [CntWidth+1:0] CntMax = {2'b00, {CntWidth{1'b1}}};

    logic ar_hs, aw_hs, atomic_hs, r_hs, r_last_hs, w_hs, b_hs;
    logic [CntWidth+1:0] ar_sum, aw_sum;
    logic [CntWidth-1:0] ar_next, aw_next;
    logic ar_under, aw_under;
    logic [CntWidth-1:0] r_acc_q, w_acc_q;
    logic unused_fields;

    assign unused_fields = ^{req_i, rsp_i};

    assign ar_hs     = req_i.ar_valid & rsp_i.ar_ready;
    assign aw_hs     = req_i.aw_valid & rsp_i.aw_ready;
    assign atomic_hs = aw_hs & req_i.aw.atop[5];
    assign r_hs      = rsp_i.r_valid & req_i.r_ready;
    assign r_last_hs = r_hs & rsp_i.r.last;
    assign w_hs      = req_i.w_valid & rsp_i.w_ready;
    assign b_hs      = rsp_i.b_valid & req_i.b_ready;

    // Net change is computed wide first so +1/-1 in the same cycle cancels even at saturation.
    always_comb begin
        ar_sum   = {2'b00, ar_in_flight_o} + (CntWidth+2)'(ar_hs) + (CntWidth+2)'(atomic_hs);
        ar_under = r_last_hs && (ar_sum == '0);
        if (r_last_hs && !ar_under) begin
            ar_sum = ar_sum - 1'b1;
        end
        ar_next = (ar_sum > CntMax) ? {CntWidth{1'b1}} : ar_sum[CntWidth-1:0];

        aw_sum   = {2'b00, aw_in_flight_o} + (CntWidth+2)'(aw_hs);
        aw_under = b_hs && (aw_sum == '0);
        if (b_hs && !aw_under) begin
            aw_sum = aw_sum - 1'b1;
        end
        aw_next = (aw_sum > CntMax) ? {CntWidth{1'b1}} : aw_sum[CntWidth-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ar_in_flight_o     <= '0;
            aw_in_flight_o     <= '0;
            max_ar_in_flight_o <= '0;
            max_aw_in_flight_o <= '0;
            error_o            <= 1'b0;
            r_acc_q            <= '0;
            w_acc_q            <= '0;
            r_beats_o          <= '0;
            w_beats_o          <= '0;
        end else if (clear_i) begin
            ar_in_flight_o     <= '0;
            aw_in_flight_o     <= '0;
            max_ar_in_flight_o <= '0;
            max_aw_in_flight_o <= '0;
            error_o            <= 1'b0;
            r_acc_q            <= '0;
            w_acc_q            <= '0;
            r_beats_o          <= '0;
            w_beats_o          <= '0;
        end else begin
            ar_in_flight_o <= ar_next;
            aw_in_flight_o <= aw_next;
            if (ar_next > max_ar_in_flight_o) max_ar_in_flight_o <= ar_next;
            if (aw_next > max_aw_in_flight_o) max_aw_in_flight_o <= aw_next;
            if (ar_under || aw_under) error_o <= 1'b1;
            if (en_i) begin
                if (tc_i) begin
                    r_beats_o <= CntWidth'(sat_add(64'(r_acc_q), 64'(r_hs), CntWidth));
                    w_beats_o <= CntWidth'(sat_add(64'(w_acc_q), 64'(w_hs), CntWidth));
                    r_acc_q   <= '0;
                    w_acc_q   <= '0;
                end else begin
                    r_acc_q <= CntWidth'(sat_add(64'(r_acc_q), 64'(r_hs), CntWidth));
                    w_acc_q <= CntWidth'(sat_add(64'(w_acc_q), 64'(w_hs), CntWidth));
                end
            end
        end
    end

endmodule

// File: rtl/floo_axi_perf_monitor.sv
// Passive multi-port AXI performance monitor: shared measurement window
// plus one counter slice per monitored port.
module floo_axi_perf_monitor
    import floo_pkg::*;
#(
    parameter int unsigned NumPorts     = 2,
    parameter int unsigned WindowCycles = 1024,
    parameter int unsigned CntWidth     = 32,
    parameter type         req_t        = axi_req_t,
    parameter type         rsp_t        = axi_rsp_t
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               en_i,
    input  logic                               clear_i,
    input  req_t [NumPorts-1:0]                req_i,
    input  rsp_t [NumPorts-1:0]                rsp_i,
    output logic                               window_valid_o,
    output logic [NumPorts-1:0][CntWidth-1:0]  r_beats_o,
    output logic [NumPorts-1:0][CntWidth-1:0]  w_beats_o,
    output logic [NumPorts-1:0][CntWidth-1:0]  ar_in_flight_o,
    output logic [NumPorts-1:0][CntWidth-1:0]  aw_in_flight_o,
    output logic [NumPorts-1:0][CntWidth-1:0]  max_ar_in_flight_o,
    output logic [NumPorts-1:0][CntWidth-1:0]  max_aw_in_flight_o,
    output logic [NumPorts-1:0]                error_o
);

    localparam int unsigned     WinWidth = win_cnt_width(WindowCycles);
    localparam logic [WinWidth-1:0] WinLast = WinWidth'(WindowCycles - 1);

    logic [WinWidth-1:0] win_cnt_q;
    logic                tc;

    assign tc = en_i && (win_cnt_q == WinLast);

    // The window only advances on enabled cycles, so disabling stretches it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_cnt_q      <= '0;
            window_valid_o <= 1'b0;
        end else if (clear_i) begin
            win_cnt_q      <= '0;
            window_valid_o <= 1'b0;
        end else begin
            window_valid_o <= tc;
            if (tc) begin
                win_cnt_q <= '0;
            end else if (en_i) begin
                win_cnt_q <= win_cnt_q + 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NumPorts; p++) begin : gen_port
        floo_axi_perf_port #(
            .CntWidth (CntWidth),
            .req_t    (req_t),
            .rsp_t    (rsp_t)
        ) i_port (
            .clk_i              (clk_i),
            .rst_ni             (rst_ni),
            .en_i               (en_i),
            .clear_i            (clear_i),
            .tc_i               (tc),
            .req_i              (req_i[p]),
            .rsp_i              (rsp_i[p]),
            .r_beats_o          (r_beats_o[p]),
            .w_beats_o          (w_beats_o[p]),
            .ar_in_flight_o     (ar_in_flight_o[p]),
            .aw_in_flight_o     (aw_in_flight_o[p]),
            .max_ar_in_flight_o (max_ar_in_flight_o[p]),
            .max_aw_in_flight_o (max_aw_in_flight_o[p]),
            .error_o            (error_o[p])
        );
    end

endmodule

// File: tb/tb_floo_axi_perf_monitor.sv
// Directed bench for floo_axi_perf_monitor: in-flight tracking, atomics,
// windowed beat counts, underflow, clear and saturation.
module tb_floo_axi_perf_monitor;
    import floo_pkg::*;

    localparam int unsigned NP = 2;
    localparam int unsigned WC = 8;
    localparam int unsigned CW = 4;

    logic clk;
    logic rst_n;
    logic en;
    logic clear;
    axi_req_t [NP-1:0] req;
    axi_rsp_t [NP-1:0] rsp;
    logic                     window_valid;
    logic [NP-1:0][CW-1:0]    r_beats, w_beats, ar_if, aw_if, max_ar, max_aw;
    logic [NP-1:0]            error;

    int checks   = 0;
    int failures = 0;

    floo_axi_perf_monitor #(
        .NumPorts     (NP),
        .WindowCycles (WC),
        .CntWidth     (CW),
        .req_t        (axi_req_t),
        .rsp_t        (axi_rsp_t)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .en_i               (en),
        .clear_i            (clear),
        .req_i              (req),
        .rsp_i              (rsp),
        .window_valid_o     (window_valid),
        .r_beats_o          (r_beats),
        .w_beats_o          (w_beats),
        .ar_in_flight_o     (ar_if),
        .aw_in_flight_o     (aw_if),
        .max_ar_in_flight_o (max_ar),
        .max_aw_in_flight_o (max_aw),
        .error_o            (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req = '0;
        rsp = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (window_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_window_valid got=%b expected=0", window_valid);
        end
        checks++;
        if ({ar_if, aw_if, max_ar, max_aw} !== '0) begin
            failures++; $display("[TB] FAIL reset_in_flight got=%h expected=0", {ar_if, aw_if, max_ar, max_aw});
        end
        checks++;
        if ({r_beats, w_beats, error} !== '0) begin
            failures++; $display("[TB] FAIL reset_beats_error got=%h expected=0", {r_beats, w_beats, error});
        end
        rst_n = 1'b1;
        step();
    endtask

    // Three ARs back-to-back followed by three R-last responses on port 0.
    task automatic test_outstanding_reads();
        int exp_seq[6] = '{1, 2, 3, 2, 1, 0};
        idle();
        req[0].ar_valid = 1'b1;
        rsp[0].ar_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                idle();
                rsp[0].r_valid = 1'b1;
                rsp[0].r.last  = 1'b1;
                req[0].r_ready = 1'b1;
            end
            step();
            checks++;
            if (ar_if[0] !== CW'(exp_seq[i])) begin
                failures++; $display("[TB] FAIL outstanding_ar[%0d] got=%0d expected=%0d", i, ar_if[0], exp_seq[i]);
            end
        end
        idle();
        checks++;
        if (max_ar[0] !== 4'd3) begin
            failures++; $display("[TB] FAIL outstanding_max_ar got=%0d expected=3", max_ar[0]);
        end
        checks++;
        if (error !== 2'b00) begin
            failures++; $display("[TB] FAIL outstanding_error got=%b expected=00", error);
        end
    endtask

    task automatic test_atomic();
        idle();
        req[1].aw_valid = 1'b1;
        req[1].aw.atop  = 6'b100000;
        rsp[1].aw_ready = 1'b1;
        step();
        checks++;
        if (ar_if[1] !== 4'd1 || aw_if[1] !== 4'd1) begin
            failures++; $display("[TB] FAIL atomic_issue got ar=%0d aw=%0d expected ar=1 aw=1", ar_if[1], aw_if[1]);
        end
        idle();
        rsp[1].r_valid = 1'b1;
        rsp[1].r.last  = 1'b1;
        req[1].r_ready = 1'b1;
        rsp[1].b_valid = 1'b1;
        req[1].b_ready = 1'b1;
        step();
        idle();
        checks++;
        if (ar_if[1] !== 4'd0 || aw_if[1] !== 4'd0 || error[1] !== 1'b0) begin
            failures++; $display("[TB] FAIL atomic_done got ar=%0d aw=%0d err=%b expected 0 0 0", ar_if[1], aw_if[1], error[1]);
        end
    endtask

    task automatic test_same_cycle();
        idle();
        req[0].ar_valid = 1'b1;
        rsp[0].ar_ready = 1'b1;
        step();
        step();
        rsp[0].r_valid = 1'b1;
        rsp[0].r.last  = 1'b1;
        req[0].r_ready = 1'b1;
        step();
        checks++;
        if (ar_if[0] !== 4'd2) begin
            failures++; $display("[TB] FAIL same_cycle_ar_r got=%0d expected=2", ar_if[0]);
        end
        req[0].ar_valid = 1'b0;
        step();
        step();
        checks++;
        if (ar_if[0] !== 4'd0) begin
            failures++; $display("[TB] FAIL same_cycle_drain got=%0d expected=0", ar_if[0]);
        end
        // AR plus atomic AW from an empty count adds two in one cycle.
        idle();
        req[0].ar_valid = 1'b1;
        rsp[0].ar_ready = 1'b1;
        req[0].aw_valid = 1'b1;
        req[0].aw.atop  = 6'b100000;
        rsp[0].aw_ready = 1'b1;
        step();
        checks++;
        if (ar_if[0] !== 4'd2 || aw_if[0] !== 4'd1) begin
            failures++; $display("[TB] FAIL same_cycle_ar_atomic got ar=%0d aw=%0d expected ar=2 aw=1", ar_if[0], aw_if[0]);
        end
        idle();
        rsp[0].r_valid = 1'b1;
        rsp[0].r.last  = 1'b1;
        req[0].r_ready = 1'b1;
        rsp[0].b_valid = 1'b1;
        req[0].b_ready = 1'b1;
        step();
        rsp[0].b_valid = 1'b0;
        step();
        idle();
        checks++;
        if (ar_if[0] !== 4'd0 || aw_if[0] !== 4'd0 || error !== 2'b00) begin
            failures++; $display("[TB] FAIL same_cycle_final got ar=%0d aw=%0d err=%b expected 0 0 00", ar_if[0], aw_if[0], error);
        end
    endtask

    task automatic test_underflow_clear();
        idle();
        rsp[0].b_valid = 1'b1;
        req[0].b_ready = 1'b1;
        step();
        idle();
        checks++;
        if (error !== 2'b01 || aw_if[0] !== 4'd0) begin
            failures++; $display("[TB] FAIL underflow_b got err=%b aw=%0d expected err=01 aw=0", error, aw_if[0]);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (error !== 2'b00 || max_ar !== '0 || max_aw !== '0) begin
            failures++; $display("[TB] FAIL clear got err=%b max_ar=%h max_aw=%h expected 0", error, max_ar, max_aw);
        end
    endtask

    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!window_valid && n < 40);
    endtask

    task automatic test_window();
        int n;
        idle();
        en    = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        en    = 1'b1;
        req[0].w_valid = 1'b1;
        rsp[0].w_ready = 1'b1;
        wait_pulse(n);
        checks++;
        if (n !== 8 || w_beats[0] !== 4'd8 || r_beats[0] !== 4'd0) begin
            failures++; $display("[TB] FAIL window_first got cycles=%0d w=%0d r=%0d expected 8 8 0", n, w_beats[0], r_beats[0]);
        end
        step();
        checks++;
        if (window_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL window_pulse_width got=%b expected=0", window_valid);
        end
        wait_pulse(n);
        checks++;
        if (n !== 7 || w_beats[0] !== 4'd8) begin
            failures++; $display("[TB] FAIL window_second got cycles=%0d w=%0d expected 7 8", n, w_beats[0]);
        end
        // Pausing en for 4 cycles mid-window delays the pulse without counting extra beats.
        repeat (3) step();
        en = 1'b0;
        repeat (4) step();
        en = 1'b1;
        wait_pulse(n);
        checks++;
        if (n !== 5 || w_beats[0] !== 4'd8) begin
            failures++; $display("[TB] FAIL window_paused got cycles=%0d w=%0d expected 5 8", n, w_beats[0]);
        end
        en = 1'b0;
        idle();
        step();
    endtask

    task automatic test_saturation_reset();
        idle();
        req[0].ar_valid = 1'b1;
        rsp[0].ar_ready = 1'b1;
        repeat (20) step();
        checks++;
        if (ar_if[0] !== 4'd15 || max_ar[0] !== 4'd15) begin
            failures++; $display("[TB] FAIL saturation got ar=%0d max=%0d expected 15 15", ar_if[0], max_ar[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ar_if, aw_if, max_ar, max_aw, r_beats, w_beats, error, window_valid} !== '0) begin
            failures++; $display("[TB] FAIL mid_reset got=%h expected=0", {ar_if, aw_if, max_ar, max_aw, r_beats, w_beats, error, window_valid});
        end
        idle();
        step();
        rst_n = 1'b1;
        rsp[0].r_valid = 1'b1;
        rsp[0].r.last  = 1'b1;
        req[0].r_ready = 1'b1;
        step();
        idle();
        checks++;
        if (error !== 2'b01 || ar_if[0] !== 4'd0) begin
            failures++; $display("[TB] FAIL forgotten_read got err=%b ar=%0d expected 01 0", error, ar_if[0]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        clear = 1'b0;
        idle();
        test_reset();
        test_outstanding_reads();
        test_atomic();
        test_same_cycle();
        test_underflow_clear();
        test_window();
        test_saturation_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
